// File: rtl/fir_pkg.sv
// fir_pkg: shared FIR datapath constants and the sample-controller FSM state type.
package fir_pkg;
    localparam int DMEM_DEPTH = 2560;
    localparam int DMEM_AW    = 12;
    localparam int SAMPLE_DW  = 16;
    localparam int TAP_W      = 8;
    typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_WAIT, RD_CAP, OUT, INIT} state_e;
endpackage

// File: rtl/fir_ring_addr.sv
// fir_ring_addr: modulo-DEPTH tap address (ptr - k) and wrapping pointer increment.
module fir_ring_addr
    import fir_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int AW    = DMEM_AW
) (
    input  logic [AW-1:0]    ptr_i,
    input  logic [TAP_W-1:0] k_i,
    output logic [AW-1:0]    addr_o,
    output logic [AW-1:0]    ptr_inc_o
);
    logic [AW-1:0] k_ext;
    always_comb begin
        k_ext     = AW'(k_i);
        addr_o    = (ptr_i < k_ext) ? ptr_i + AW'(DEPTH) - k_ext : ptr_i - k_ext;
        ptr_inc_o = (ptr_i == AW'(DEPTH - 1)) ? '0 : ptr_i + AW'(1);
    end
endmodule

// File: rtl/fir_sample_ctrl.sv
// fir_sample_ctrl: circular sample buffer over dmem10, streams newest NTAPS samples per input.
// Define SCTRL_ZERO_INIT_EN to zero the whole buffer after reset instead of masking via fill.
module fir_sample_ctrl
    import fir_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int NTAPS = 32,
    parameter int AW    = DMEM_AW,
    parameter int DW    = SAMPLE_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [7:0]    out_tap,
    output logic          out_last,
    output logic          mem_cen,
    output logic          mem_wen,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_q
);
    localparam logic [TAP_W:0]   FILL_MAX = (TAP_W + 1)'(NTAPS);
    localparam logic [TAP_W-1:0] K_LAST   = TAP_W'(NTAPS - 1);

    state_e           state_q;
    logic [AW-1:0]    wr_ptr_q, rd_addr, ptr_inc;
    logic [TAP_W:0]   fill_q;
    logic [TAP_W-1:0] k_q;
    logic             in_ready_q, out_valid_q, out_last_q, mem_cen_q, mem_wen_q;
    logic [DW-1:0]    out_data_q, mem_d_q;
    logic [7:0]       out_tap_q;
    logic [AW-1:0]    mem_a_q;

    fir_ring_addr #(.DEPTH(DEPTH), .AW(AW)) u_ring (
        .ptr_i    (wr_ptr_q),
        .k_i      (k_q),
        .addr_o   (rd_addr),
        .ptr_inc_o(ptr_inc)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tap   = out_tap_q;
    assign out_last  = out_last_q;
    assign mem_cen   = mem_cen_q;
    assign mem_wen   = mem_wen_q;
    assign mem_a     = mem_a_q;
    assign mem_d     = mem_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef SCTRL_ZERO_INIT_EN
            state_q     <= INIT;
`else
            state_q     <= IDLE;
`endif
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            k_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tap_q   <= '0;
            out_last_q  <= 1'b0;
            mem_cen_q   <= 1'b1;
            mem_wen_q   <= 1'b1;
            mem_a_q     <= '0;
            mem_d_q     <= '0;
        end else begin
            case (state_q)
`ifdef SCTRL_ZERO_INIT_EN
                INIT: begin
                    // mem_a doubles as the clear counter; cen still high marks the first cycle
                    if (mem_cen_q) begin
                        mem_cen_q <= 1'b0;
                        mem_wen_q <= 1'b0;
                        mem_a_q   <= '0;
                        mem_d_q   <= '0;
                    end else if (mem_a_q == AW'(DEPTH - 1)) begin
                        mem_cen_q  <= 1'b1;
                        mem_wen_q  <= 1'b1;
                        mem_a_q    <= '0;
                        fill_q     <= FILL_MAX;
                        in_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        mem_a_q <= mem_a_q + AW'(1);
                    end
                end
`endif
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        mem_d_q    <= in_data;
                        mem_a_q    <= wr_ptr_q;
                        mem_cen_q  <= 1'b0;
                        mem_wen_q  <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= WR;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                WR: begin
                    mem_cen_q <= 1'b1;
                    mem_wen_q <= 1'b1;
                    fill_q    <= (fill_q >= FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
                    k_q       <= '0;
                    state_q   <= RD_ADDR;
                end
                RD_ADDR: begin
                    out_tap_q  <= k_q;
                    out_last_q <= (k_q == K_LAST);
                    // taps beyond the samples written since reset read as zero
                    if ({1'b0, k_q} < fill_q) begin
                        mem_a_q   <= rd_addr;
                        mem_cen_q <= 1'b0;
                        mem_wen_q <= 1'b1;
                        state_q   <= RD_WAIT;
                    end else begin
                        out_data_q  <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end
                end
                RD_WAIT: begin
                    mem_cen_q <= 1'b1;
                    state_q   <= RD_CAP;
                end
                RD_CAP: begin
                    out_data_q  <= mem_q;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            wr_ptr_q   <= ptr_inc;
                            in_ready_q <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            k_q     <= k_q + 1'b1;
                            state_q <= RD_ADDR;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
